// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: LEGv8 pipelined control. Decodes the 11-instruction
// subset in D, carries control bits through E and POST_EX_STAGES later stages,
// owns the NZVC flags register and resolves branches in E.
// Optional macro BCOND_FULL_EN: B.cond evaluates the full condition from
// instruction[3:0]; when undefined every B.cond evaluates as LT (N xor V).
module pipelined_control_unit #(
   parameter int unsigned ALUOP_W        = 3,
   parameter int unsigned POST_EX_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [31:0]        instruction,
   input  logic               stall,
   input  logic               alu_zero,
   input  logic               alu_negative,
   input  logic               alu_overflow,
   input  logic               alu_carry,
   output logic               id_Reg2Loc,
   output logic               id_illegal,
   output logic               ex_valid,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic               ex_ALUSrc,
   output logic               ex_BrTaken,
   output logic               ex_UncondBr,
   output logic               flush,
   output logic               mem_MemWrite,
   output logic               mem_MemRead,
   output logic               wb_RegWrite,
   output logic               wb_MemToReg,
   output logic [3:0]         flags
);

   localparam int unsigned LAST = POST_EX_STAGES - 1;

   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_LSR   = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_XOR   = 3'b110;

   // opcode matches
   logic w_is_addi, w_is_adds, w_is_and, w_is_eor, w_is_lsr, w_is_subs;
   logic w_is_ldur, w_is_stur, w_is_b, w_is_bcond, w_is_cbz;
   logic w_is_rtype, w_match, w_legal;

   assign w_is_addi  = (instruction[31:22] == 10'b1001000100);
   assign w_is_adds  = (instruction[31:21] == 11'b10101011000);
   assign w_is_and   = (instruction[31:21] == 11'b10001010000);
   assign w_is_eor   = (instruction[31:21] == 11'b11001010000);
   assign w_is_lsr   = (instruction[31:21] == 11'b11010011010);
   assign w_is_subs  = (instruction[31:21] == 11'b11101011000);
   assign w_is_ldur  = (instruction[31:21] == 11'b11111000010);
   assign w_is_stur  = (instruction[31:21] == 11'b11111000000);
   assign w_is_b     = (instruction[31:26] == 6'b000101);
   assign w_is_bcond = (instruction[31:24] == 8'b01010100);
   assign w_is_cbz   = (instruction[31:24] == 8'b10110100);

   assign w_is_rtype = w_is_adds | w_is_and | w_is_eor | w_is_lsr | w_is_subs;
   assign w_match    = w_is_rtype | w_is_addi | w_is_ldur | w_is_stur |
                       w_is_b | w_is_bcond | w_is_cbz;
   assign w_legal    = instr_valid & w_match;

   // low instruction bits carry register/immediate fields not used here
   logic w_unused_instr;
   assign w_unused_instr = ^instruction[20:0];

   logic [2:0] w_dec_aluop;
   logic       w_dec_alusrc, w_dec_reg2loc, w_dec_regwrite, w_dec_memtoreg;
   logic       w_dec_memread, w_dec_memwrite, w_dec_weflags;
   logic       w_dec_uncond, w_dec_cbz, w_dec_bcond;

   // D-stage decode; invalid or unmatched instructions decode as all-zero NOP
   always_comb begin
      w_dec_aluop    = ALU_PASSB;
      w_dec_alusrc   = 1'b0;
      w_dec_reg2loc  = 1'b0;
      w_dec_regwrite = 1'b0;
      w_dec_memtoreg = 1'b0;
      w_dec_memread  = 1'b0;
      w_dec_memwrite = 1'b0;
      w_dec_weflags  = 1'b0;
      w_dec_uncond   = 1'b0;
      w_dec_cbz      = 1'b0;
      w_dec_bcond    = 1'b0;
      if (w_legal) begin
         w_dec_alusrc   = w_is_addi | w_is_ldur | w_is_stur;
         w_dec_reg2loc  = w_is_rtype | w_is_addi;
         w_dec_regwrite = w_is_rtype | w_is_addi | w_is_ldur;
         w_dec_memtoreg = w_is_ldur;
         w_dec_memread  = w_is_ldur;
         w_dec_memwrite = w_is_stur;
         w_dec_weflags  = w_is_adds | w_is_subs;
         w_dec_uncond   = w_is_b;
         w_dec_cbz      = w_is_cbz;
         w_dec_bcond    = w_is_bcond;
         if (w_is_cbz)
            w_dec_aluop = ALU_PASSB;
         else if (w_is_lsr)
            w_dec_aluop = ALU_LSR;
         else if (w_is_addi | w_is_adds | w_is_ldur | w_is_stur | w_is_b)
            w_dec_aluop = ALU_ADD;
         else if (w_is_subs | w_is_bcond)
            w_dec_aluop = ALU_SUB;
         else if (w_is_and)
            w_dec_aluop = ALU_AND;
         else if (w_is_eor)
            w_dec_aluop = ALU_XOR;
      end
   end

   assign id_Reg2Loc = w_dec_reg2loc;
   assign id_illegal = instr_valid & ~w_match;

   // E-stage control registers
   logic               r_ex_valid, r_ex_alusrc, r_ex_regwrite, r_ex_memtoreg;
   logic               r_ex_memread, r_ex_memwrite, r_ex_weflags;
   logic               r_ex_uncond, r_ex_cbz, r_ex_bcond;
   logic [ALUOP_W-1:0] r_ex_aluop;
   logic [3:0]         r_flags;
   logic               w_cond_true, w_br_taken;

`ifdef BCOND_FULL_EN
   logic [3:0] r_ex_cond;
   logic       w_n, w_z, w_v, w_c;
   assign {w_n, w_z, w_v, w_c} = r_flags;

   // full LEGv8 condition evaluation on the latched cond field
   always_comb begin
      w_cond_true = 1'b1;
      case (r_ex_cond)
         4'h0:    w_cond_true = w_z;
         4'h1:    w_cond_true = ~w_z;
         4'h2:    w_cond_true = w_c;
         4'h3:    w_cond_true = ~w_c;
         4'h4:    w_cond_true = w_n;
         4'h5:    w_cond_true = ~w_n;
         4'h6:    w_cond_true = w_v;
         4'h7:    w_cond_true = ~w_v;
         4'h8:    w_cond_true = w_c & ~w_z;
         4'h9:    w_cond_true = ~(w_c & ~w_z);
         4'hA:    w_cond_true = (w_n == w_v);
         4'hB:    w_cond_true = (w_n != w_v);
         4'hC:    w_cond_true = ~w_z & (w_n == w_v);
         4'hD:    w_cond_true = ~(~w_z & (w_n == w_v));
         default: w_cond_true = 1'b1;
      endcase
   end
`else
   assign w_cond_true = r_flags[3] ^ r_flags[1];
`endif

   assign w_br_taken = r_ex_valid & (r_ex_uncond |
                                     (r_ex_cbz & alu_zero) |
                                     (r_ex_bcond & w_cond_true));

   assign ex_valid    = r_ex_valid;
   assign ex_ALUOp    = r_ex_aluop;
   assign ex_ALUSrc   = r_ex_alusrc;
   assign ex_UncondBr = r_ex_uncond;
   assign ex_BrTaken  = w_br_taken;
   assign flush       = w_br_taken;
   assign flags       = r_flags;

   // D->E transfer: reset, flush and stall each leave a bubble in E
   always_ff @(posedge clk) begin
      if (reset || w_br_taken || stall) begin
         r_ex_valid    <= 1'b0;
         r_ex_aluop    <= '0;
         r_ex_alusrc   <= 1'b0;
         r_ex_regwrite <= 1'b0;
         r_ex_memtoreg <= 1'b0;
         r_ex_memread  <= 1'b0;
         r_ex_memwrite <= 1'b0;
         r_ex_weflags  <= 1'b0;
         r_ex_uncond   <= 1'b0;
         r_ex_cbz      <= 1'b0;
         r_ex_bcond    <= 1'b0;
`ifdef BCOND_FULL_EN
         r_ex_cond     <= 4'h0;
`endif
      end else begin
         r_ex_valid    <= w_legal;
         r_ex_aluop    <= ALUOP_W'(w_dec_aluop);
         r_ex_alusrc   <= w_dec_alusrc;
         r_ex_regwrite <= w_dec_regwrite;
         r_ex_memtoreg <= w_dec_memtoreg;
         r_ex_memread  <= w_dec_memread;
         r_ex_memwrite <= w_dec_memwrite;
         r_ex_weflags  <= w_dec_weflags;
         r_ex_uncond   <= w_dec_uncond;
         r_ex_cbz      <= w_dec_cbz;
         r_ex_bcond    <= w_dec_bcond;
`ifdef BCOND_FULL_EN
         r_ex_cond     <= instruction[3:0];
`endif
      end
   end

   // NZVC register, written by a live flag-setting instruction in E
   always_ff @(posedge clk) begin
      if (reset)
         r_flags <= 4'b0000;
      else if (r_ex_valid && r_ex_weflags)
         r_flags <= {alu_negative, alu_zero, alu_overflow, alu_carry};
   end

   // post-E stages: index 0 is M, index LAST is W; they always advance
   logic [POST_EX_STAGES-1:0] r_st_valid, r_st_regwrite, r_st_memtoreg;
   logic                      r_mem_memwrite, r_mem_memread;

   // shift control bits down the post-E chain, gated by each stage's valid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st_valid     <= '0;
         r_st_regwrite  <= '0;
         r_st_memtoreg  <= '0;
         r_mem_memwrite <= 1'b0;
         r_mem_memread  <= 1'b0;
      end else begin
         r_st_valid     <= POST_EX_STAGES'({r_st_valid, r_ex_valid});
         r_st_regwrite  <= POST_EX_STAGES'({r_st_regwrite & r_st_valid,
                                            r_ex_regwrite & r_ex_valid});
         r_st_memtoreg  <= POST_EX_STAGES'({r_st_memtoreg & r_st_valid,
                                            r_ex_memtoreg & r_ex_valid});
         r_mem_memwrite <= r_ex_memwrite & r_ex_valid;
         r_mem_memread  <= r_ex_memread & r_ex_valid;
      end
   end

   assign mem_MemWrite = r_mem_memwrite;
   assign mem_MemRead  = r_mem_memread;
   assign wb_RegWrite  = r_st_regwrite[LAST];
   assign wb_MemToReg  = r_st_memtoreg[LAST];

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: an instruction-level model
// (history of what occupied E each cycle plus an NZVC register) is compared
// against the DUT every cycle, backed by directed literal checks.
module tb_pipelined_control_unit;

   localparam int unsigned ALUOP_W = 3;
   localparam int unsigned P       = 2;

   logic               clk, reset, instr_valid, stall;
   logic [31:0]        instruction;
   logic               alu_zero, alu_negative, alu_overflow, alu_carry;
   logic               id_Reg2Loc, id_illegal, ex_valid, ex_ALUSrc, ex_BrTaken;
   logic               ex_UncondBr, flush, mem_MemWrite, mem_MemRead;
   logic               wb_RegWrite, wb_MemToReg;
   logic [ALUOP_W-1:0] ex_ALUOp;
   logic [3:0]         flags;

   pipelined_control_unit #(.ALUOP_W(ALUOP_W), .POST_EX_STAGES(P)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid),
      .instruction(instruction), .stall(stall), .alu_zero(alu_zero),
      .alu_negative(alu_negative), .alu_overflow(alu_overflow),
      .alu_carry(alu_carry), .id_Reg2Loc(id_Reg2Loc), .id_illegal(id_illegal),
      .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc),
      .ex_BrTaken(ex_BrTaken), .ex_UncondBr(ex_UncondBr), .flush(flush),
      .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
      .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] I_ADDI = 32'h9100_0000;
   localparam logic [31:0] I_ADDS = 32'hAB00_0000;
   localparam logic [31:0] I_AND  = 32'h8A00_0000;
   localparam logic [31:0] I_EOR  = 32'hCA00_0000;
   localparam logic [31:0] I_LSR  = 32'hD340_0000;
   localparam logic [31:0] I_SUBS = 32'hEB00_0000;
   localparam logic [31:0] I_LDUR = 32'hF840_0000;
   localparam logic [31:0] I_STUR = 32'hF800_0000;
   localparam logic [31:0] I_B    = 32'h1400_0000;
   localparam logic [31:0] I_BC   = 32'h5400_0000;
   localparam logic [31:0] I_CBZ  = 32'hB400_0000;

   typedef enum logic [3:0] {K_NOP, K_ADDI, K_ADDS, K_AND, K_EOR, K_LSR,
                             K_SUBS, K_LDUR, K_STUR, K_B, K_BCOND, K_CBZ} kind_e;
   typedef struct packed { logic v; kind_e k; logic [3:0] cond; } rec_t;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic kind_e classify(input logic [31:0] ins);
      logic [10:0] op;
      op = ins[31:21];
      if (ins[31:22] == 10'b1001000100) return K_ADDI;
      if (ins[31:26] == 6'b000101)      return K_B;
      if (ins[31:24] == 8'h54)          return K_BCOND;
      if (ins[31:24] == 8'hB4)          return K_CBZ;
      case (op)
         11'b10101011000: return K_ADDS;
         11'b10001010000: return K_AND;
         11'b11001010000: return K_EOR;
         11'b11010011010: return K_LSR;
         11'b11101011000: return K_SUBS;
         11'b11111000010: return K_LDUR;
         11'b11111000000: return K_STUR;
         default:         return K_NOP;
      endcase
   endfunction

   function automatic int exp_aluop(input kind_e k);
      case (k)
         K_LSR:                              return 1;
         K_ADDI, K_ADDS, K_LDUR, K_STUR, K_B: return 2;
         K_SUBS, K_BCOND:                    return 3;
         K_AND:                              return 4;
         K_EOR:                              return 6;
         default:                            return 0;
      endcase
   endfunction

   function automatic bit uses_rm(input kind_e k);
      return k inside {K_ADDI, K_ADDS, K_AND, K_EOR, K_LSR, K_SUBS};
   endfunction

   function automatic bit writes_reg(input kind_e k);
      return k inside {K_ADDI, K_ADDS, K_AND, K_EOR, K_LSR, K_SUBS, K_LDUR};
   endfunction

   // condition check written in the ARM "base test, odd code inverts" form
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, v, cy, base;
      n = f[3]; z = f[2]; v = f[1]; cy = f[0];
`ifdef BCOND_FULL_EN
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return (c[0] && c != 4'hF) ? !base : base;
`else
      base = c[0];
      return base ? (n != v) : (n != v);
`endif
   endfunction

   function automatic bit taken_exp(input rec_t r, input logic [3:0] f, input logic z);
      if (!r.v) return 1'b0;
      case (r.k)
         K_B:     return 1'b1;
         K_CBZ:   return z;
         K_BCOND: return cond_ok(r.cond, f);
         default: return 1'b0;
      endcase
   endfunction

   // model: hist[0] is the instruction in E, hist[k] was in E k cycles ago
   rec_t     hist [0:7];
   logic [3:0] m_flags;
   bit       m_known = 0;
   rec_t     m_nx;
   bit       m_taken;
   kind_e    m_dk;

   always begin : model
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) hist[i] = '0;
         m_flags = 4'b0000;
         m_known = 1;
      end else if (m_known) begin
         m_taken = taken_exp(hist[0], m_flags, alu_zero);
         if (hist[0].v && (hist[0].k == K_ADDS || hist[0].k == K_SUBS))
            m_flags = {alu_negative, alu_zero, alu_overflow, alu_carry};
         m_nx = '0;
         m_dk = classify(instruction);
         if (!m_taken && !stall && instr_valid && m_dk != K_NOP) begin
            m_nx.v    = 1'b1;
            m_nx.k    = m_dk;
            m_nx.cond = instruction[3:0];
         end
         for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = m_nx;
      end
   end

   // per-cycle comparison of every output against the model
   always begin : compare
      kind_e dk;
      bit    tk;
      @(negedge clk);
      if (m_known) begin
         dk = classify(instruction);
         tk = taken_exp(hist[0], m_flags, alu_zero);
         chk("id_illegal", int'(id_illegal), int'(instr_valid && dk == K_NOP));
         chk("id_Reg2Loc", int'(id_Reg2Loc), int'(instr_valid && uses_rm(dk)));
         chk("ex_valid", int'(ex_valid), int'(hist[0].v));
         chk("ex_ALUOp", int'(ex_ALUOp), hist[0].v ? exp_aluop(hist[0].k) : 0);
         chk("ex_ALUSrc", int'(ex_ALUSrc),
             int'(hist[0].v && hist[0].k inside {K_ADDI, K_LDUR, K_STUR}));
         chk("ex_UncondBr", int'(ex_UncondBr), int'(hist[0].v && hist[0].k == K_B));
         chk("ex_BrTaken", int'(ex_BrTaken), int'(tk));
         chk("flush", int'(flush), int'(tk));
         chk("mem_MemWrite", int'(mem_MemWrite), int'(hist[1].v && hist[1].k == K_STUR));
         chk("mem_MemRead", int'(mem_MemRead), int'(hist[1].v && hist[1].k == K_LDUR));
         chk("wb_RegWrite", int'(wb_RegWrite), int'(hist[P].v && writes_reg(hist[P].k)));
         chk("wb_MemToReg", int'(wb_MemToReg), int'(hist[P].v && hist[P].k == K_LDUR));
         chk("flags", int'(flags), int'(m_flags));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic st,
                        input logic [3:0] nzvc);
      instr_valid = v;
      instruction = ins;
      stall       = st;
      {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
      #1;
   endtask

   logic [31:0] tbl [0:12];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      tbl[0] = I_ADDI; tbl[1] = I_ADDS; tbl[2]  = I_AND;  tbl[3]  = I_EOR;
      tbl[4] = I_LSR;  tbl[5] = I_SUBS; tbl[6]  = I_LDUR; tbl[7]  = I_STUR;
      tbl[8] = I_B;    tbl[9] = I_BC;   tbl[10] = I_CBZ;  tbl[11] = 32'hFFFF_FFFF;
      tbl[12] = 32'h0000_0000;

      // reset held two cycles with ADDI in D
      reset = 1'b1;
      drive(1'b1, I_ADDI, 1'b0, 4'b0000);
      tick(); tick();
      chk("rst_ex_valid", int'(ex_valid), 0);
      chk("rst_flags", int'(flags), 0);
      chk("rst_wb_RegWrite", int'(wb_RegWrite), 0);
      chk("rst_mem_MemRead", int'(mem_MemRead), 0);
      reset = 1'b0;
      #1;
      chk("addi_id_Reg2Loc", int'(id_Reg2Loc), 1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0000);
      chk("addi_ex_ALUSrc", int'(ex_ALUSrc), 1);
      chk("addi_ex_ALUOp", int'(ex_ALUOp), 2);
      repeat (P) tick();
      chk("addi_wb_RegWrite", int'(wb_RegWrite), 1);

      // SUBS sets N, then B.LT is taken and kills the following instruction
      drive(1'b1, I_SUBS, 1'b0, 4'b0000);
      tick();
      drive(1'b1, I_BC | 32'hB, 1'b0, 4'b1000);
      tick();
      drive(1'b1, I_ADDI, 1'b0, 4'b0000);
      chk("blt_flags", int'(flags), 8);
      chk("blt_taken", int'(ex_BrTaken), 1);
      chk("blt_flush", int'(flush), 1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0000);
      chk("blt_victim_ex_valid", int'(ex_valid), 0);

      // CBZ not taken then taken
      drive(1'b1, I_CBZ, 1'b0, 4'b0000);
      tick();
      drive(1'b1, I_CBZ, 1'b0, 4'b0000);
      chk("cbz0_taken", int'(ex_BrTaken), 0);
      chk("cbz_ALUOp", int'(ex_ALUOp), 0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0100);
      chk("cbz1_taken", int'(ex_BrTaken), 1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0000);

      // LDUR followed by a one-cycle load-use stall on ADDS
      drive(1'b1, I_LDUR, 1'b0, 4'b1111);
      tick();
      drive(1'b1, I_ADDS, 1'b1, 4'b1111);
      tick();
      drive(1'b1, I_ADDS, 1'b0, 4'b1111);
      chk("stall_bubble", int'(ex_valid), 0);
      chk("ldur_MemRead", int'(mem_MemRead), 1);
      chk("stall_flags", int'(flags), 8);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0100);
      chk("adds_enters", int'(ex_valid), 1);
      chk("bubble_MemRead", int'(mem_MemRead), 0);
      chk("bubble_flags", int'(flags), 8);
      tick();

      // B flushes a STUR in D; illegal word decodes as bubble
      drive(1'b1, I_B, 1'b0, 4'b0000);
      chk("adds_flags", int'(flags), 4);
      tick();
      drive(1'b1, I_STUR, 1'b0, 4'b0000);
      chk("b_taken", int'(ex_BrTaken), 1);
      chk("b_uncond", int'(ex_UncondBr), 1);
      tick();
      drive(1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0000);
      chk("illegal_id", int'(id_illegal), 1);
      chk("flushed_stur_MemWrite", int'(mem_MemWrite), 0);
      tick();
      drive(1'b0, 32'hFFFF_FFFF, 1'b0, 4'b0000);
      chk("invalid_not_illegal", int'(id_illegal), 0);
      chk("illegal_ex_valid", int'(ex_valid), 0);
      drive(1'b1, I_STUR, 1'b0, 4'b0000);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0000);
      tick();
      chk("stur_MemWrite", int'(mem_MemWrite), 1);

      // B.EQ with flags 0100
      drive(1'b1, I_BC, 1'b0, 4'b0000);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0000);
`ifdef BCOND_FULL_EN
      chk("beq_taken", int'(ex_BrTaken), 1);
`else
      chk("beq_taken", int'(ex_BrTaken), 0);
`endif
      tick();

      // flush and stall in the same cycle
      drive(1'b1, I_B, 1'b0, 4'b0000);
      tick();
      drive(1'b1, I_ADDI, 1'b1, 4'b0000);
      chk("fs_flush", int'(flush), 1);
      tick();
      drive(1'b1, I_ADDI, 1'b0, 4'b0000);
      chk("fs_bubble", int'(ex_valid), 0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 4'b0000);
      chk("fs_after", int'(ex_valid), 1);

      // mixed traffic with a mid-stream reset, checked by the model
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ins;
         ins = tbl[$urandom_range(0, 12)];
         if (ins == I_BC) ins = ins | 32'($urandom_range(0, 15));
         reset = (i == 150);
         drive(1'($urandom_range(0, 7) != 0), ins, 1'($urandom_range(0, 5) == 0),
               4'($urandom_range(0, 15)));
         tick();
      end
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 4'b0000);
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
